// File: rtl/parking_gate_ctrl.sv
// Clocked parking gate controller: shared entry/exit gate, coded entry, door watchdog.
// Optional wrong-code lockout is built when PARKING_LOCKOUT_EN is defined.
module parking_gate_ctrl #(
    parameter int              CAPACITY     = 8,
    parameter int              CNT_W        = 4,
    parameter int              PASS_W       = 6,
    parameter logic [PASS_W-1:0] PASSWORD   = 6'd45,
    parameter int              MAX_TRIES    = 3,
    parameter int              LOCK_CYCLES  = 16,
    parameter int              DOOR_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              entranceSen,
    input  logic [PASS_W-1:0] entrancePass,
    input  logic              passValid,
    input  logic              exitSen,
    input  logic              doorMaxOpen,
    input  logic              doorMaxClose,
    output logic              doorOpen,
    output logic              doorClose,
    output logic              okPass,
    output logic              wrongPass,
    output logic              locked,
    output logic              doorFault,
    output logic [CNT_W-1:0]  carNumber,
    output logic              empty,
    output logic              full
);

    localparam int TMW = $clog2(DOOR_TIMEOUT + 1);
    localparam logic [TMW-1:0]   TMO_LAST = TMW'(DOOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE,
        OPENING,
        CLOSING,
        FAULT
    } state_e;

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [TMW-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             wrong_q, wrong_d;
    logic             open_q, close_q, fault_q;
    logic             empty_q, full_q;
    logic             lock_w;
    logic             exit_req, entry_req;

    assign exit_req  = exitSen && !empty_q;
    assign entry_req = entranceSen && passValid && !full_q && !lock_w;

    // dir: 1 = car coming in, 0 = car going out
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        ok_d    = 1'b0;
        wrong_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (exit_req) begin
                    dir_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = OPENING;
                end else if (entry_req) begin
                    if (entrancePass == PASSWORD) begin
                        ok_d    = 1'b1;
                        dir_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = OPENING;
                    end else begin
                        wrong_d = 1'b1;
                    end
                end
            end
            OPENING: begin
                if (doorMaxOpen) begin
                    tmo_d   = '0;
                    state_d = CLOSING;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CLOSING: begin
                if (doorMaxClose) begin
                    state_d = IDLE;
                    if (dir_q && cnt_q < CAP)
                        cnt_d = cnt_q + 1'b1;
                    else if (!dir_q && cnt_q != '0)
                        cnt_d = cnt_q - 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            wrong_q <= 1'b0;
            open_q  <= 1'b0;
            close_q <= 1'b0;
            fault_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            wrong_q <= wrong_d;
            open_q  <= (state_d == OPENING);
            close_q <= (state_d == CLOSING);
            fault_q <= (state_d == FAULT);
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CAP);
        end
    end

`ifdef PARKING_LOCKOUT_EN
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int LKW = $clog2(LOCK_CYCLES + 1);

    logic [TRW-1:0] tries_q, tries_d;
    logic [LKW-1:0] lock_q, lock_d;
    logic           locked_q, locked_d;

    // locked rises with the final wrongPass pulse and lasts LOCK_CYCLES clocks
    always_comb begin
        tries_d  = tries_q;
        lock_d   = lock_q;
        locked_d = locked_q;
        if (locked_q) begin
            lock_d   = lock_q - 1'b1;
            locked_d = (lock_q > LKW'(1));
        end
        if (ok_d) begin
            tries_d = '0;
        end else if (wrong_d) begin
            if (tries_q == TRW'(MAX_TRIES - 1)) begin
                tries_d  = '0;
                lock_d   = LKW'(LOCK_CYCLES);
                locked_d = 1'b1;
            end else begin
                tries_d = tries_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q  <= '0;
            lock_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            tries_q  <= tries_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
        end
    end

    assign lock_w = locked_q;
`else
    assign lock_w = 1'b0;
`endif

    assign doorOpen  = open_q;
    assign doorClose = close_q;
    assign okPass    = ok_q;
    assign wrongPass = wrong_q;
    assign locked    = lock_w;
    assign doorFault = fault_q;
    assign carNumber = cnt_q;
    assign empty     = empty_q;
    assign full      = full_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: entry, capacity, lockout, exit priority,
// door watchdog and asynchronous reset.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entranceSen = 1'b0;
    logic [5:0] entrancePass = '0;
    logic       passValid = 1'b0;
    logic       exitSen = 1'b0;
    logic       doorMaxOpen = 1'b0;
    logic       doorMaxClose = 1'b0;
    logic       doorOpen, doorClose, okPass, wrongPass;
    logic       locked, doorFault, empty, full;
    logic [3:0] carNumber;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parking_gate_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entranceSen  (entranceSen),
        .entrancePass (entrancePass),
        .passValid    (passValid),
        .exitSen      (exitSen),
        .doorMaxOpen  (doorMaxOpen),
        .doorMaxClose (doorMaxClose),
        .doorOpen     (doorOpen),
        .doorClose    (doorClose),
        .okPass       (okPass),
        .wrongPass    (wrongPass),
        .locked       (locked),
        .doorFault    (doorFault),
        .carNumber    (carNumber),
        .empty        (empty),
        .full         (full)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [5:0] code, input logic exp_ok,
                          input logic exp_wrong);
        @(negedge clk);
        entranceSen  = 1'b1;
        passValid    = 1'b1;
        entrancePass = code;
        @(negedge clk);
        entranceSen = 1'b0;
        passValid   = 1'b0;
        check("okPass", okPass, exp_ok);
        check("wrongPass", wrongPass, exp_wrong);
        check("doorOpen_after_code", doorOpen, exp_ok);
    endtask

    task automatic door_cycle();
        @(negedge clk);
        check("okPass_one_cycle", okPass, 0);
        check("still_opening", doorOpen, 1);
        doorMaxOpen = 1'b1;
        @(negedge clk);
        doorMaxOpen = 1'b0;
        check("open_drop", doorOpen, 0);
        check("close_drive", doorClose, 1);
        @(negedge clk);
        doorMaxClose = 1'b1;
        @(negedge clk);
        doorMaxClose = 1'b0;
        check("close_drop", doorClose, 0);
    endtask

    task automatic exit_car();
        @(negedge clk);
        exitSen = 1'b1;
        @(negedge clk);
        exitSen = 1'b0;
        check("exit_open", doorOpen, 1);
        door_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int n;

    initial begin
        do_reset();
        check("rst_doorOpen", doorOpen, 0);
        check("rst_doorClose", doorClose, 0);
        check("rst_okPass", okPass, 0);
        check("rst_wrongPass", wrongPass, 0);
        check("rst_locked", locked, 0);
        check("rst_doorFault", doorFault, 0);
        check("rst_carNumber", carNumber, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);

        strobe(6'd45, 1, 0);
        door_cycle();
        check("first_count", carNumber, 1);
        check("first_empty", empty, 0);

        for (int i = 0; i < 7; i++) begin
            strobe(6'd45, 1, 0);
            door_cycle();
        end
        check("count_full", carNumber, 8);
        check("full_flag", full, 1);

        strobe(6'd45, 0, 0);
        repeat (3) @(negedge clk);
        check("full_door_closed", doorOpen, 0);
        check("full_count_kept", carNumber, 8);

        for (int i = 0; i < 6; i++) exit_car();
        check("count_two", carNumber, 2);
        check("not_full", full, 0);

        @(negedge clk);
        exitSen      = 1'b1;
        entranceSen  = 1'b1;
        passValid    = 1'b1;
        entrancePass = 6'd45;
        @(negedge clk);
        exitSen     = 1'b0;
        entranceSen = 1'b0;
        passValid   = 1'b0;
        check("conflict_no_ok", okPass, 0);
        check("conflict_no_wrong", wrongPass, 0);
        check("conflict_open", doorOpen, 1);
        door_cycle();
        check("conflict_count", carNumber, 1);

        exit_car();
        check("count_zero", carNumber, 0);
        check("empty_again", empty, 1);
        @(negedge clk);
        exitSen = 1'b1;
        @(negedge clk);
        exitSen = 1'b0;
        check("empty_exit_ignored", doorOpen, 0);

        strobe(6'd1, 0, 1);
        strobe(6'd2, 0, 1);
        strobe(6'd3, 0, 1);
`ifdef PARKING_LOCKOUT_EN
        check("locked_rise", locked, 1);
        n = 0;
        while (locked && n < 100) begin
            n++;
            if (n == 2) begin
                entranceSen  = 1'b1;
                passValid    = 1'b1;
                entrancePass = 6'd45;
            end else begin
                entranceSen = 1'b0;
                passValid   = 1'b0;
            end
            if (n == 3) begin
                check("locked_no_ok", okPass, 0);
                check("locked_no_open", doorOpen, 0);
            end
            @(negedge clk);
        end
        entranceSen = 1'b0;
        passValid   = 1'b0;
        check("lock_cycles", n, 16);
`else
        check("no_lockout", locked, 0);
`endif
        strobe(6'd45, 1, 0);
        door_cycle();
        check("post_lock_count", carNumber, 1);

        strobe(6'd45, 1, 0);
        @(negedge clk);
        doorMaxOpen = 1'b1;
        @(negedge clk);
        doorMaxOpen = 1'b0;
        check("pre_rst_closing", doorClose, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_close", doorClose, 0);
        check("async_open", doorOpen, 0);
        check("async_count", carNumber, 0);
        check("async_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;

        strobe(6'd45, 1, 0);
        repeat (25) @(negedge clk);
        check("tmo_not_yet", doorFault, 0);
        check("tmo_opening", doorOpen, 1);
        repeat (15) @(negedge clk);
        check("fault_set", doorFault, 1);
        check("fault_open", doorOpen, 0);
        check("fault_close", doorClose, 0);
        doorMaxOpen = 1'b1;
        exitSen     = 1'b1;
        repeat (3) @(negedge clk);
        doorMaxOpen = 1'b0;
        exitSen     = 1'b0;
        strobe(6'd45, 0, 0);
        check("fault_sticky", doorFault, 1);
        check("fault_no_close", doorClose, 0);
        do_reset();
        check("fault_cleared", doorFault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
